gerador_comandos: RTL and testbench
===================================

Name: gerador_comandos

Overview:
- Produces the command inputs (a, b, c, d) consumed by the lighting-control FSM, from raw board signals.
- Converts one push button into short-press (b: manual lamp toggle) and long-press (a: auto/manual mode change) pulses.
- Filters the presence sensor into d.
- Runs the auto-mode off-timer: when the FSM asserts enable_sub_3 (lamp on in auto), it raises c after TIMEOUT_CYC cycles without presence.

Parameters:
- DEBOUNCE_CYC, 1000: consecutive stable cycles needed to accept a new level on a filtered input.
- LONG_PRESS_CYC, 300000: held-press cycles that qualify a press as long.
- TIMEOUT_CYC, 500000: auto-off cycles without presence before c pulses.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- botao  in  1  raw push button, active-high, asynchronous, bouncy
- sensor  in  1  raw presence sensor, active-high, asynchronous
- enable_sub_3  in  1  from lighting FSM, high while lamp on in auto mode
- a  out  1  one-cycle pulse, long press
- b  out  1  one-cycle pulse, short press
- c  out  1  one-cycle pulse, auto-off timeout
- d  out  1  level, debounced presence

Behaviour:
- Reset and clocking: one clock domain; reset is synchronous and active-high. On reset, a=b=c=d=0, all synchronizers, filters and counters are 0, and the classifier is in OCIOSO.
- Input path: botao and sensor each pass through a 2-FF synchronizer, then a debounce filter.
  - Filter holds a stable level and a run counter.
  - When the synced input differs from stable, the counter increments; when equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYC-1 with the input still differing, stable takes the input and the counter clears.
  - Total latency from raw edge to stable change: 2 + DEBOUNCE_CYC cycles.
  - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- d: registered copy of the debounced sensor level (one additional cycle).
- Press classifier FSM, states OCIOSO, PRESSIONADO, SEGURANDO, driven by the debounced button bt:
  - OCIOSO: bt=1 -> PRESSIONADO, press counter=0.
  - PRESSIONADO, bt=0: b=1 for one cycle -> OCIOSO.
  - PRESSIONADO, bt=1, counter=LONG_PRESS_CYC-1: a=1 for one cycle -> SEGURANDO. The long press fires while the button is still held; the later release produces nothing.
  - PRESSIONADO otherwise: counter increments.
  - SEGURANDO: bt=0 -> OCIOSO; else stay.
  - a and b are never asserted in the same cycle. At most one pulse per press.
- Off-timer (counter width $clog2(TIMEOUT_CYC)):
  - enable_sub_3=0: counter=0, c=0.
  - enable_sub_3=1 and d=1: counter=0 (presence retriggers).
  - enable_sub_3=1 and d=0: counter increments. At TIMEOUT_CYC-1, c=1 for one cycle and the counter wraps to 0.
  - If enable_sub_3 stays high after c, timing restarts from 0; no back-to-back c.
  - enable_sub_3 falling mid-count discards the count; a later rise starts from 0.
- Simultaneous events: c is independent of a/b and may coincide with them. The FSM's own priority resolves the conflict; this block does not arbitrate.
- Reset mid-press or mid-count: state and counters clear; no pulse is emitted for the interrupted event.
- Registered outputs: all outputs come directly from flops, with no combinational path from inputs.

Decomposition:
- Shared package pkg_comandos: the classifier state enum typedef (OCIOSO, PRESSIONADO, SEGURANDO), 2-bit encoding.
- Sub-module filtro_debounce (parameter DEBOUNCE_CYC; ports clk, rst, entrada, saida) contains synchronizer plus filter. It is instantiated twice (botao, sensor).
- Classifier and timer stay in gerador_comandos.

Test Plan (DEBOUNCE_CYC=4, LONG_PRESS_CYC=20, TIMEOUT_CYC=50):
- Reset: assert rst 3 cycles with botao=sensor=1 -> a=b=c=d=0 during reset and in the first cycle after.
- Bounce rejection: botao toggled every 2 cycles for 20 cycles, then low -> no a or b ever.
- Short press: botao held 12 cycles, released -> exactly one b pulse of 1 cycle, 6 cycles after release (2 sync + 4 debounce), shifted by the registration stage; a stays 0.
- Long press: botao held 40 cycles -> one a pulse 20 cycles after the debounced rise, while still held; release gives no b.
- Timeout: sensor=0, enable_sub_3 held high -> c pulses on cycle 50 and cycle 100; enable_sub_3 dropped at cycle 30 then raised -> next c 50 cycles after the re-rise.
- Presence retrigger: enable_sub_3=1, sensor pulse of 10 cycles at cycle 40 -> d high for 10 cycles (after 7-cycle latency); no c until 50 cycles after d falls.

Source files
------------

// File: rtl/gerador_comandos_pkg.sv
// Shared types for the lighting-control command generator.
package pkg_comandos;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        PRESSIONADO = 2'd1,
        SEGURANDO   = 2'd2
    } estado_t;

endpackage

// File: rtl/filtro_debounce.sv
// Two-flop synchronizer followed by a run-length debounce filter.
module filtro_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic entrada,
    output logic saida
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            saida <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= entrada;
            sync2 <= sync1;
            // Any sample agreeing with the stable level restarts the run.
            if (sync2 != saida) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    saida <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gerador_comandos.sv
// Builds the a/b/c/d commands for the lighting FSM from button, sensor and auto-off timer.
module gerador_comandos
    import pkg_comandos::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 1000,
    parameter int unsigned LONG_PRESS_CYC = 300000,
    parameter int unsigned TIMEOUT_CYC    = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    input  logic sensor,
    input  logic enable_sub_3,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    localparam int unsigned PW = (LONG_PRESS_CYC > 1) ? $clog2(LONG_PRESS_CYC) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic bt;
    logic presenca;

    filtro_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filtro_botao (
        .clk(clk), .rst(rst), .entrada(botao), .saida(bt)
    );

    filtro_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filtro_sensor (
        .clk(clk), .rst(rst), .entrada(sensor), .saida(presenca)
    );

    always_ff @(posedge clk) begin
        if (rst) d <= 1'b0;
        else     d <= presenca;
    end

    estado_t       estado, prox_estado;
    logic [PW-1:0] cnt_press, prox_cnt;
    logic          a_prox, b_prox;
    logic          longo;

    assign longo = (cnt_press == PW'(LONG_PRESS_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            cnt_press <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
        end else begin
            estado    <= prox_estado;
            cnt_press <= prox_cnt;
            a         <= a_prox;
            b         <= b_prox;
        end
    end

    always_comb begin
        prox_estado = estado;
        prox_cnt    = cnt_press;
        unique case (estado)
            OCIOSO: begin
                if (bt) begin
                    prox_estado = PRESSIONADO;
                    prox_cnt    = '0;
                end
            end
            PRESSIONADO: begin
                if (!bt)        prox_estado = OCIOSO;
                else if (longo) prox_estado = SEGURANDO;
                else            prox_cnt    = cnt_press + PW'(1);
            end
            SEGURANDO: begin
                if (!bt) prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // Pulses are computed here and registered with the state so a/b come straight from flops.
    always_comb begin
        a_prox = 1'b0;
        b_prox = 1'b0;
        if (estado == PRESSIONADO) begin
            a_prox = bt && longo;
            b_prox = !bt;
        end
    end

    logic [TW-1:0] cnt_tempo;

    always_ff @(posedge clk) begin
        if (rst || !enable_sub_3 || d) begin
            cnt_tempo <= '0;
            c         <= 1'b0;
        end else if (cnt_tempo == TW'(TIMEOUT_CYC - 1)) begin
            cnt_tempo <= '0;
            c         <= 1'b1;
        end else begin
            cnt_tempo <= cnt_tempo + TW'(1);
            c         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gerador_comandos.sv
// Randomized and directed checks of gerador_comandos against a window/run-length reference model.
module tb_gerador_comandos;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int TMO  = 50;
    localparam int QN   = 2 + DEB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic botao = 1'b0;
    logic sensor = 1'b0;
    logic enable_sub_3 = 1'b0;
    logic a, b, c, d;

    always #5 clk = ~clk;

    gerador_comandos #(
        .DEBOUNCE_CYC(DEB),
        .LONG_PRESS_CYC(LONG),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .botao(botao), .sensor(sensor),
        .enable_sub_3(enable_sub_3), .a(a), .b(b), .c(c), .d(d)
    );

    int checks = 0;
    int failures = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Reference model state: raw sample history, accepted levels, press length, idle run.
    bit qb[QN];
    bit qs[QN];
    bit mb, ms, md;
    bit ea, eb, ec;
    int press_len, idle_run;

    int na, nb, nc, nd, n_ciclo, t_c, a_com_botao;

    task automatic modelo_passo();
        bit bt_old, s_old, d_old, vira_b, vira_s;
        if (rst) begin
            for (int i = 0; i < QN; i++) begin qb[i] = 0; qs[i] = 0; end
            mb = 0; ms = 0; md = 0; ea = 0; eb = 0; ec = 0;
            press_len = 0; idle_run = 0;
            return;
        end
        bt_old = mb; s_old = ms; d_old = md;
        for (int i = 0; i < QN - 1; i++) begin qb[i] = qb[i+1]; qs[i] = qs[i+1]; end
        qb[QN-1] = botao;
        qs[QN-1] = sensor;
        // A level is accepted once the last DEB synchronized samples all disagree with it.
        vira_b = 1; vira_s = 1;
        for (int i = 0; i < DEB; i++) begin
            if (qb[i] == mb) vira_b = 0;
            if (qs[i] == ms) vira_s = 0;
        end
        if (vira_b) mb = ~mb;
        if (vira_s) ms = ~ms;
        md = s_old;
        ea = 0; eb = 0;
        if (bt_old) begin
            press_len++;
            if (press_len == LONG + 1) ea = 1;
        end else begin
            if (press_len > 0 && press_len <= LONG) eb = 1;
            press_len = 0;
        end
        if (enable_sub_3 && !d_old) begin
            idle_run++;
            ec = (idle_run % TMO == 0);
        end else begin
            idle_run = 0;
            ec = 0;
        end
    endtask

    task automatic ciclo(input bit bt, input bit sn, input bit en, input bit r);
        botao = bt; sensor = sn; enable_sub_3 = en; rst = r;
        @(posedge clk);
        modelo_passo();
        #1;
        verifica("a", a, ea);
        verifica("b", b, eb);
        verifica("c", c, ec);
        verifica("d", d, md);
        verifica("a_b_exclusivos", a & b, 0);
        if (a === 1'b1) begin na++; if (botao) a_com_botao++; end
        if (b === 1'b1) nb++;
        if (c === 1'b1) begin nc++; if (t_c < 0) t_c = n_ciclo; end
        if (d === 1'b1) nd++;
        n_ciclo++;
    endtask

    task automatic zera_contagem();
        na = 0; nb = 0; nc = 0; nd = 0; n_ciclo = 0; t_c = -1; a_com_botao = 0;
    endtask

    initial begin
        int rb, rs, re;
        bit vb, vs, ve;

        zera_contagem();
        for (int i = 0; i < 3; i++) ciclo(1, 1, 0, 1);
        ciclo(0, 0, 0, 0);
        verifica("reset_a", a, 0);
        verifica("reset_d", d, 0);
        for (int i = 0; i < 10; i++) ciclo(0, 0, 0, 0);

        zera_contagem();
        for (int i = 0; i < 20; i++) ciclo(((i / 2) % 2) == 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) ciclo(0, 0, 0, 0);
        verifica("bounce_a", na, 0);
        verifica("bounce_b", nb, 0);

        zera_contagem();
        for (int i = 0; i < 12; i++) ciclo(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) ciclo(0, 0, 0, 0);
        verifica("short_b", nb, 1);
        verifica("short_a", na, 0);

        zera_contagem();
        for (int i = 0; i < 40; i++) ciclo(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) ciclo(0, 0, 0, 0);
        verifica("long_a", na, 1);
        verifica("long_a_held", a_com_botao, 1);
        verifica("long_b", nb, 0);

        zera_contagem();
        for (int i = 0; i < 110; i++) ciclo(0, 0, 1, 0);
        verifica("timeout_c_count", nc, 2);
        verifica("timeout_c_first", t_c, TMO - 1);
        ciclo(0, 0, 0, 0);

        zera_contagem();
        for (int i = 0; i < 30; i++) ciclo(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) ciclo(0, 0, 0, 0);
        verifica("drop_no_c", nc, 0);
        zera_contagem();
        for (int i = 0; i < 60; i++) ciclo(0, 0, 1, 0);
        verifica("rerise_c_count", nc, 1);
        verifica("rerise_c_time", t_c, TMO - 1);
        ciclo(0, 0, 0, 0);

        zera_contagem();
        for (int i = 0; i < 40; i++) ciclo(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) ciclo(0, 1, 1, 0);
        for (int i = 0; i < 55; i++) ciclo(0, 0, 1, 0);
        verifica("presence_d_len", nd, 10);
        verifica("presence_no_c", nc, 0);
        for (int i = 0; i < 10; i++) ciclo(0, 0, 1, 0);
        verifica("presence_c_after", nc, 1);
        ciclo(0, 0, 0, 0);

        zera_contagem();
        for (int i = 0; i < 15; i++) ciclo(1, 0, 1, 0);
        ciclo(1, 0, 1, 1);
        for (int i = 0; i < 40; i++) ciclo(0, 0, 1, 0);
        verifica("rst_mid_a", na, 0);
        verifica("rst_mid_b", nb, 0);
        verifica("rst_mid_c", nc, 0);

        zera_contagem();
        rb = 0; rs = 0; re = 0; vb = 0; vs = 0; ve = 0;
        for (int i = 0; i < 1500; i++) begin
            if (rb == 0) begin vb = ~vb; rb = $urandom_range(1, 40); end
            if (rs == 0) begin vs = ~vs; rs = $urandom_range(1, 80); end
            if (re == 0) begin ve = ~ve; re = $urandom_range(1, 150); end
            rb--; rs--; re--;
            ciclo(vb, vs, ve, $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
